// File: rtl/frame_receiver.sv
// -----------------------------------------------------------------------------
// frame_receiver
//
// Receive side of the encoder/modulator link. The oversampled serial line is
// synchronised and a phase counter is realigned on every line transition to
// find the middle of each bit. In HUNT the receiver slides incoming bits
// through a shift register until the sync word appears. It then switches to
// DATA and collects FRAME_WORDS Hamming(7,4) codewords. Each codeword is
// corrected for a single-bit error and emitted as a nibble with a one-cycle
// strobe.
//
// Optional build macro: FRAME_RX_ERR_COUNT_EN
//   When defined, adds err_count_o: a saturating count of corrected words.
//
// Parameters
//   OSR          clk cycles per line bit (even, >= 4)
//   SYNC_WORD    frame sync pattern, MSB received first
//   FRAME_WORDS  codewords per frame after sync (1..255)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   data_i       asynchronous serial line
//   data_o       decoded nibble {d1,d2,d3,d4}, held until the next strobe
//   valid_o      one-cycle strobe qualifying data_o / corrected_o
//   corrected_o  a nonzero syndrome was corrected in this codeword
//   locked_o     high while a frame is being received
//   err_count_o  (FRAME_RX_ERR_COUNT_EN only) corrected-word count, saturating
// -----------------------------------------------------------------------------
module frame_receiver #(
   parameter int         OSR         = 8,
   parameter logic [7:0] SYNC_WORD   = 8'b1101_0011,
   parameter int         FRAME_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_i,
   output logic [3:0]  data_o,
   output logic        valid_o,
   output logic        corrected_o,
   output logic        locked_o
`ifdef FRAME_RX_ERR_COUNT_EN
   ,
   output logic [15:0] err_count_o
`endif
);

   localparam int            PW        = $clog2(OSR);
   localparam logic [PW-1:0] HALF      = PW'(OSR / 2);
   localparam logic [PW-1:0] LAST      = PW'(OSR - 1);
   localparam logic [7:0]    LAST_WORD = 8'(FRAME_WORDS - 1);

   typedef enum logic {
      HUNT,
      DATA
   } state_t;

   state_t        state;
   logic          sync_1;
   logic          sync_q;
   logic          prev_q;
   logic [PW-1:0] phase;
   // Holds the last 7 received bits; the 8th comes straight from sync_q so the
   // match is seen in the strobe cycle itself.
   logic [6:0]    hunt_sr;
   logic [6:1]    cw;
   logic [2:0]    idx;
   logic [7:0]    word_cnt;

   logic          line_edge;
   logic          strobe;
   logic [7:0]    hunt_next;
   logic [7:1]    cw_full;
   logic [2:0]    syn;
   logic [3:0]    data_fix;

   always_comb begin
      line_edge = sync_q ^ prev_q;
      // An edge in the mid-bit cycle realigns instead of sampling.
      strobe    = !line_edge && (phase == HALF);
      hunt_next = {hunt_sr, sync_q};
      // Position 7 is the bit being sampled right now.
      cw_full   = {sync_q, cw};
      syn[0]    = cw_full[1] ^ cw_full[3] ^ cw_full[5] ^ cw_full[7];
      syn[1]    = cw_full[2] ^ cw_full[3] ^ cw_full[6] ^ cw_full[7];
      syn[2]    = cw_full[4] ^ cw_full[5] ^ cw_full[6] ^ cw_full[7];
      // Only data positions need flipping; a parity-position error leaves the
      // nibble untouched.
      data_fix  = {cw_full[3] ^ (syn == 3'd3),
                   cw_full[5] ^ (syn == 3'd5),
                   cw_full[6] ^ (syn == 3'd6),
                   cw_full[7] ^ (syn == 3'd7)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= HUNT;
         sync_1      <= 1'b0;
         sync_q      <= 1'b0;
         prev_q      <= 1'b0;
         phase       <= '0;
         hunt_sr     <= '0;
         cw          <= '0;
         idx         <= '0;
         word_cnt    <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         corrected_o <= 1'b0;
         locked_o    <= 1'b0;
      end else begin
         sync_1   <= data_i;
         sync_q   <= sync_1;
         prev_q   <= sync_q;

         if (line_edge)
            phase <= PW'(1);
         else if (phase == LAST)
            phase <= '0;
         else
            phase <= phase + PW'(1);

         valid_o  <= 1'b0;
         // Lags state by one cycle, so lock stays up through the last strobe.
         locked_o <= (state == DATA);

         case (state)
            HUNT: begin
               if (strobe) begin
                  hunt_sr <= hunt_next[6:0];
                  if (hunt_next == SYNC_WORD) begin
                     state    <= DATA;
                     idx      <= 3'd1;
                     word_cnt <= '0;
                     cw       <= '0;
                  end
               end
            end

            DATA: begin
               if (strobe) begin
                  if (idx == 3'd7) begin
                     valid_o     <= 1'b1;
                     data_o      <= data_fix;
                     corrected_o <= (syn != 3'd0);
                     idx         <= 3'd1;
                     if (word_cnt == LAST_WORD) begin
                        state    <= HUNT;
                        hunt_sr  <= '0;
                        word_cnt <= '0;
                     end else begin
                        word_cnt <= word_cnt + 8'd1;
                     end
                  end else begin
                     for (int unsigned i = 1; i <= 6; i++) begin
                        if (idx == 3'(i))
                           cw[i] <= sync_q;
                     end
                     idx <= idx + 3'd1;
                  end
               end
            end

            default: state <= HUNT;
         endcase
      end
   end

`ifdef FRAME_RX_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         err_count_o <= '0;
      else if (valid_o && corrected_o && (err_count_o != 16'hFFFF))
         err_count_o <= err_count_o + 16'd1;
   end
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// -----------------------------------------------------------------------------
// Testbench for frame_receiver (OSR = 8, default sync word, 4 words/frame).
// Expected nibbles are pushed to a queue as codewords are transmitted and
// popped by a monitor whenever valid_o is seen.
// -----------------------------------------------------------------------------
module tb_frame_receiver;

   localparam int         OSR  = 8;
   localparam logic [7:0] SYNC = 8'b1101_0011;

   logic        clk = 1'b0;
   logic        reset;
   logic        data_i;
   logic [3:0]  data_o;
   logic        valid_o;
   logic        corrected_o;
   logic        locked_o;
`ifdef FRAME_RX_ERR_COUNT_EN
   logic [15:0] err_count_o;
`endif

   frame_receiver #(
      .OSR         (OSR),
      .SYNC_WORD   (SYNC),
      .FRAME_WORDS (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_i      (data_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .corrected_o (corrected_o),
      .locked_o    (locked_o)
`ifdef FRAME_RX_ERR_COUNT_EN
      ,
      .err_count_o (err_count_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] data;
      logic       corr;
   } exp_t;

   exp_t exp_q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   valid_seen = 0;

   // Codeword bits [7:1] = {d4, d3, d2, p3, d1, p2, p1}
   function automatic logic [7:1] encode(input logic [3:0] nib);
      logic d1, d2, d3, d4;
      d1 = nib[3];
      d2 = nib[2];
      d3 = nib[1];
      d4 = nib[0];
      return {d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
   endfunction

   // All senders start and end on a falling edge.
   task automatic send_bit(input logic b, input int n);
      data_i = b;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] v, input int n);
      for (int i = 7; i >= 0; i--)
         send_bit(v[i], n);
   endtask

   task automatic send_cw(input logic [3:0] nib, input int flip, input int n);
      logic [7:1] cw;
      exp_t       e;
      cw = encode(nib);
      if (flip != 0)
         cw[flip] = ~cw[flip];
      e.data = nib;
      e.corr = (flip != 0);
      exp_q.push_back(e);
      for (int p = 1; p <= 7; p++)
         send_bit(cw[p], n);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (valid_o) begin
         valid_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid data_o=%b corrected_o=%b", data_o, corrected_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (data_o !== e.data) begin
               errors++;
               $display("FAIL data_o got=%b exp=%b", data_o, e.data);
            end
            checks++;
            if (corrected_o !== e.corr) begin
               errors++;
               $display("FAIL corrected_o got=%b exp=%b", corrected_o, e.corr);
            end
            checks++;
            if (locked_o !== 1'b1) begin
               errors++;
               $display("FAIL locked_during_valid got=%b exp=1", locked_o);
            end
         end
      end
   end

   task automatic check_idle_end(input string name, input int vs_before, input int nexp);
      repeat (2) @(negedge clk);
      checks++;
      if (locked_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_locked_after got=%b exp=0", name, locked_o);
      end
      checks++;
      if (valid_seen - vs_before != nexp) begin
         errors++;
         $display("FAIL %s_valid_count got=%0d exp=%0d", name, valid_seen - vs_before, nexp);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending got=%0d exp=0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      data_i = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({data_o, valid_o, corrected_o, locked_o} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=0000000",
                  {data_o, valid_o, corrected_o, locked_o});
      end
      reset = 1'b0;
      send_byte(8'h00, OSR);
   endtask

   task automatic test_clean();
      int vs;
      vs = valid_seen;
      send_byte(SYNC, OSR);
      send_cw(4'b1011, 0, OSR);
      checks++;
      if (locked_o !== 1'b1) begin
         errors++;
         $display("FAIL clean_locked_mid got=%b exp=1", locked_o);
      end
      send_cw(4'b0000, 0, OSR);
      send_cw(4'b1111, 0, OSR);
      send_cw(4'b0110, 0, OSR);
      check_idle_end("clean", vs, 4);
   endtask

   task automatic test_single_error();
      int vs;
`ifdef FRAME_RX_ERR_COUNT_EN
      logic [15:0] ec0;
      ec0 = err_count_o;
`endif
      vs = valid_seen;
      send_byte(8'h00, OSR);
      send_byte(SYNC, OSR);
      send_cw(4'b1011, 5, OSR);
      send_cw(4'b0110, 1, OSR);
      send_cw(4'b0000, 7, OSR);
      send_cw(4'b1111, 3, OSR);
      check_idle_end("single_err", vs, 4);
`ifdef FRAME_RX_ERR_COUNT_EN
      checks++;
      if (err_count_o !== ec0 + 16'd4) begin
         errors++;
         $display("FAIL err_count got=%0d exp=%0d", err_count_o, ec0 + 16'd4);
      end
`endif
   endtask

   task automatic test_sync_search();
      int vs;
      vs = valid_seen;
      send_byte(8'hFF, OSR);
      send_byte(8'h00, OSR);
      checks++;
      if (locked_o !== 1'b0) begin
         errors++;
         $display("FAIL hunt_locked_before got=%b exp=0", locked_o);
      end
      send_byte(SYNC, OSR);
      send_cw(4'b0101, 0, OSR);
      checks++;
      if (locked_o !== 1'b1) begin
         errors++;
         $display("FAIL hunt_locked_mid got=%b exp=1", locked_o);
      end
      send_cw(4'b1001, 0, OSR);
      send_cw(4'b1100, 0, OSR);
      send_cw(4'b0011, 0, OSR);
      check_idle_end("hunt", vs, 4);

      vs = valid_seen;
      send_byte(8'h00, OSR);
      send_byte(8'b1101_0010, OSR);
      send_byte(8'h00, OSR);
      send_byte(8'h00, OSR);
      check_idle_end("bad_sync", vs, 0);
   endtask

   task automatic test_drift();
      int vs;
      int lens[2];
      lens[0] = OSR + 1;
      lens[1] = OSR - 1;
      foreach (lens[k]) begin
         vs = valid_seen;
         send_byte(8'h00, lens[k]);
         send_byte(SYNC, lens[k]);
         send_cw(4'b1010, 0, lens[k]);
         send_cw(4'b0101, 0, lens[k]);
         send_cw(4'b1010, 0, lens[k]);
         send_cw(4'b0101, 0, lens[k]);
         check_idle_end(k == 0 ? "drift_slow" : "drift_fast", vs, 4);
      end
   endtask

   task automatic test_reset_mid();
      int vs;
      vs = valid_seen;
      send_byte(8'h00, OSR);
      send_byte(SYNC, OSR);
      send_cw(4'b0011, 0, OSR);
      for (int i = 0; i < 4; i++)
         send_bit(1'b1, OSR);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({data_o, valid_o, corrected_o, locked_o} !== 7'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%b exp=0000000",
                  {data_o, valid_o, corrected_o, locked_o});
      end
      for (int i = 0; i < 3; i++)
         send_bit(1'b1, OSR);
      send_byte(8'h00, OSR);
      send_byte(8'h00, OSR);
      check_idle_end("reset_mid", vs, 1);

      vs = valid_seen;
      send_byte(SYNC, OSR);
      send_cw(4'b1110, 0, OSR);
      send_cw(4'b0001, 6, OSR);
      send_cw(4'b1000, 2, OSR);
      send_cw(4'b0111, 0, OSR);
      check_idle_end("resync", vs, 4);
   endtask

   initial begin
      reset  = 1'b1;
      data_i = 1'b0;
      @(negedge clk);
      test_reset();
      test_clean();
      test_single_error();
      test_sync_search();
      test_drift();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
